adsr_env_gen: RTL and testbench

Gate-driven, parametrised ADSR envelope generator with run-time programmable attack/decay/release rates and sustain level. Multiplies each incoming signed audio sample by an unsigned linear envelope. Sits between the oscillator/mixer and the codec sample path, one sample per codec request. Unlike the fixed-timing predecessor, it responds to note on/off, supports retrigger from the current level, and holds sustain indefinitely.

---
 rtl/adsr_env_gen.sv | 151 +++++++++++++++
 tb/tb_adsr_env_gen.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_env_gen.sv
// ADSR envelope generator: gate-driven attack/decay/sustain/release envelope
// with run-time programmable rates, applied to a signed audio sample stream.
// The envelope and the two-stage multiply pipeline advance only on in_ready.

module adsr_env_gen #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ENV_WIDTH    = 16,
  parameter int RATE_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_ready,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                           gate,
  input  logic        [RATE_WIDTH-1:0]   attack_step,
  input  logic        [RATE_WIDTH-1:0]   decay_step,
  input  logic        [ENV_WIDTH-1:0]    sustain_level,
  input  logic        [RATE_WIDTH-1:0]   release_step,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           out_ready,
  output logic        [2:0]              env_state,
  output logic        [ENV_WIDTH-1:0]    env_level,
  output logic                           active
);

  // Envelope arithmetic width: one bit wider than the wider of envelope and
  // step, so sums and comparisons never wrap.
  localparam int CW = ((ENV_WIDTH > RATE_WIDTH) ? ENV_WIDTH : RATE_WIDTH) + 1;
  localparam int PW = SAMPLE_WIDTH + ENV_WIDTH + 1;

  localparam logic [ENV_WIDTH-1:0] ENV_MAX   = {ENV_WIDTH{1'b1}};
  localparam logic [CW-1:0]        ENV_MAX_C = CW'(ENV_MAX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t state;

  logic [CW-1:0]        env_c;
  logic [CW-1:0]        attack_c;
  logic [CW-1:0]        decay_c;
  logic [CW-1:0]        sustain_c;
  logic [CW-1:0]        release_c;
  logic [CW-1:0]        attack_sum;
  logic [CW-1:0]        decay_floor;
  logic [ENV_WIDTH-1:0] env_after_decay;
  logic [ENV_WIDTH-1:0] env_after_release;

  logic signed [SAMPLE_WIDTH-1:0] s1_sample;
  logic        [ENV_WIDTH-1:0]    s1_env;
  logic                           s1_valid;
  logic signed [PW-1:0]           product;

  assign env_c     = CW'(env_level);
  assign attack_c  = CW'(attack_step);
  assign decay_c   = CW'(decay_step);
  assign sustain_c = CW'(sustain_level);
  assign release_c = CW'(release_step);

  // Decay clamps once the envelope would reach or cross the sustain level,
  // i.e. env <= sustain + step; release floors when env <= step.
  assign attack_sum        = env_c + attack_c;
  assign decay_floor       = sustain_c + decay_c;
  assign env_after_decay   = ENV_WIDTH'(env_c - decay_c);
  assign env_after_release = ENV_WIDTH'(env_c - release_c);

  assign env_state = state;
  assign active    = (state != IDLE);

  // Envelope state machine: one step per in_ready strobe, gate release wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      env_level <= '0;
    end else if (in_ready) begin
      case (state)
        IDLE: begin
          if (gate) state <= ATTACK;
        end
        ATTACK: begin
          if (!gate) begin
            state <= RELEASE;
          end else if (attack_sum >= ENV_MAX_C) begin
            env_level <= ENV_MAX;
            state     <= DECAY;
          end else begin
            env_level <= ENV_WIDTH'(attack_sum);
          end
        end
        DECAY: begin
          if (!gate) begin
            state <= RELEASE;
          end else if (env_c <= decay_floor) begin
            env_level <= sustain_level;
            state     <= SUSTAIN;
          end else begin
            env_level <= env_after_decay;
          end
        end
        SUSTAIN: begin
          if (!gate) state <= RELEASE;
          else       env_level <= sustain_level;
        end
        RELEASE: begin
          if (gate) begin
            state <= ATTACK;
          end else if (env_c <= release_c) begin
            env_level <= '0;
            state     <= IDLE;
          end else begin
            env_level <= env_after_release;
          end
        end
        default: begin
          state     <= IDLE;
          env_level <= '0;
        end
      endcase
    end
  end

  // Signed sample times zero-extended unsigned envelope, full precision.
  assign product = PW'(s1_sample) * PW'($signed({1'b0, s1_env}));

  // Two-stage pipeline: capture sample with pre-update envelope, then scale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_sample  <= '0;
      s1_env     <= '0;
      s1_valid   <= 1'b0;
      sample_out <= '0;
      out_ready  <= 1'b0;
    end else begin
      s1_valid  <= in_ready;
      out_ready <= s1_valid;
      if (in_ready) begin
        s1_sample <= sample_in;
        s1_env    <= env_level;
      end
      if (s1_valid) begin
        sample_out <= SAMPLE_WIDTH'(product >>> ENV_WIDTH);
      end
    end
  end

endmodule

// File: tb/tb_adsr_env_gen.sv
// Directed testbench for adsr_env_gen: envelope sequencing, pipeline timing
// and sample scaling against hand-computed values.

module tb_adsr_env_gen;

  logic               clk;
  logic               reset;
  logic               in_ready;
  logic signed [15:0] sample_in;
  logic               gate;
  logic        [15:0] attack_step;
  logic        [15:0] decay_step;
  logic        [15:0] sustain_level;
  logic        [15:0] release_step;
  logic signed [15:0] sample_out;
  logic               out_ready;
  logic        [2:0]  env_state;
  logic        [15:0] env_level;
  logic               active;

  int checks;
  int errors;

  adsr_env_gen #(
    .SAMPLE_WIDTH(16),
    .ENV_WIDTH(16),
    .RATE_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_ready(in_ready),
    .sample_in(sample_in),
    .gate(gate),
    .attack_step(attack_step),
    .decay_step(decay_step),
    .sustain_level(sustain_level),
    .release_step(release_step),
    .sample_out(sample_out),
    .out_ready(out_ready),
    .env_state(env_state),
    .env_level(env_level),
    .active(active)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One in_ready strobe launched on a falling edge; returns on the next
  // falling edge, after the envelope has updated.
  task automatic pulse(input logic g, input logic signed [15:0] s);
    @(negedge clk);
    in_ready  = 1'b1;
    gate      = g;
    sample_in = s;
    @(negedge clk);
    in_ready  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (env_state !== 3'd0 || env_level !== 16'd0 || out_ready !== 1'b0 ||
        sample_out !== 16'sd0 || active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_initial: state=%0d env=%0d rdy=%b out=%0d act=%b required 0 0 0 0 0",
               env_state, env_level, out_ready, sample_out, active);
    end
    attack_step = 16'd30000;
    pulse(1'b1, 16'sd1000);
    pulse(1'b1, 16'sd1000);
    checks++;
    if (env_state !== 3'd1 || env_level !== 16'd30000) begin
      errors++;
      $display("[TB] FAIL reset_setup: state=%0d env=%0d required 1 30000", env_state, env_level);
    end
    @(negedge clk);
    in_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (env_state !== 3'd0 || env_level !== 16'd0 || out_ready !== 1'b0 ||
        sample_out !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL reset_async: state=%0d env=%0d rdy=%b out=%0d required 0 0 0 0",
               env_state, env_level, out_ready, sample_out);
    end
    in_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_full_cycle();
    logic [15:0] exp_env   [8];
    logic [2:0]  exp_state [8];
    exp_env   = '{16384, 32768, 49152, 65535, 57343, 49151, 40959, 32768};
    exp_state = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
    do_reset();
    attack_step   = 16'd16384;
    decay_step    = 16'd8192;
    sustain_level = 16'd32768;
    release_step  = 16'd4096;
    pulse(1'b1, 16'sh7FFF);
    checks++;
    if (env_state !== 3'd1 || env_level !== 16'd0 || active !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_idle_to_attack: state=%0d env=%0d act=%b required 1 0 1",
               env_state, env_level, active);
    end
    for (int i = 0; i < 8; i++) begin
      pulse(1'b1, 16'sh7FFF);
      checks++;
      if (env_state !== exp_state[i] || env_level !== exp_env[i]) begin
        errors++;
        $display("[TB] FAIL full_ads_%0d: state=%0d env=%0d required %0d %0d",
                 i, env_state, env_level, exp_state[i], exp_env[i]);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      pulse(1'b0, 16'sh7FFF);
      checks++;
      if (i == 1) begin
        if (env_state !== 3'd4 || env_level !== 16'd32768) begin
          errors++;
          $display("[TB] FAIL full_release_enter: state=%0d env=%0d required 4 32768",
                   env_state, env_level);
        end
      end else if (env_level !== 16'(32768 - 4096 * (i - 1)) || env_state !== 3'd4) begin
        errors++;
        $display("[TB] FAIL full_release_%0d: state=%0d env=%0d required 4 %0d",
                 i, env_state, env_level, 32768 - 4096 * (i - 1));
      end
    end
    pulse(1'b0, 16'sh7FFF);
    checks++;
    if (env_state !== 3'd0 || env_level !== 16'd0 || active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_idle: state=%0d env=%0d act=%b required 0 0 0",
               env_state, env_level, active);
    end
  endtask

  task automatic test_latency();
    do_reset();
    attack_step = 16'd32768;
    pulse(1'b1, 16'sd0);
    pulse(1'b1, 16'sd0);
    pulse(1'b1, -16'sd20000);
    checks++;
    if (out_ready !== 1'b0 || env_state !== 3'd2 || env_level !== 16'd65535) begin
      errors++;
      $display("[TB] FAIL latency_cycle1: rdy=%b state=%0d env=%0d required 0 2 65535",
               out_ready, env_state, env_level);
    end
    @(negedge clk);
    checks++;
    if (out_ready !== 1'b1 || sample_out !== -16'sd10000) begin
      errors++;
      $display("[TB] FAIL latency_cycle2: rdy=%b out=%0d required 1 -10000", out_ready, sample_out);
    end
    @(negedge clk);
    checks++;
    if (out_ready !== 1'b0 || sample_out !== -16'sd10000) begin
      errors++;
      $display("[TB] FAIL latency_cycle3: rdy=%b out=%0d required 0 -10000", out_ready, sample_out);
    end
  endtask

  task automatic test_early_release_retrigger();
    do_reset();
    attack_step  = 16'd16384;
    release_step = 16'd4096;
    pulse(1'b1, 16'sd0);
    pulse(1'b1, 16'sd0);
    pulse(1'b1, 16'sd0);
    pulse(1'b0, 16'sd0);
    checks++;
    if (env_state !== 3'd4 || env_level !== 16'd32768) begin
      errors++;
      $display("[TB] FAIL early_release: state=%0d env=%0d required 4 32768", env_state, env_level);
    end
    pulse(1'b0, 16'sd0);
    checks++;
    if (env_level !== 16'd28672) begin
      errors++;
      $display("[TB] FAIL early_release_step: env=%0d required 28672", env_level);
    end
    for (int i = 0; i < 4; i++) pulse(1'b0, 16'sd0);
    checks++;
    if (env_state !== 3'd4 || env_level !== 16'd12288) begin
      errors++;
      $display("[TB] FAIL retrigger_setup: state=%0d env=%0d required 4 12288", env_state, env_level);
    end
    pulse(1'b1, 16'sd0);
    checks++;
    if (env_state !== 3'd1 || env_level !== 16'd12288) begin
      errors++;
      $display("[TB] FAIL retrigger_enter: state=%0d env=%0d required 1 12288", env_state, env_level);
    end
    pulse(1'b1, 16'sd0);
    checks++;
    if (env_level !== 16'd28672) begin
      errors++;
      $display("[TB] FAIL retrigger_step: env=%0d required 28672", env_level);
    end
  endtask

  task automatic test_saturation_zero();
    do_reset();
    pulse(1'b0, -16'sd1);
    @(negedge clk);
    checks++;
    if (out_ready !== 1'b1 || sample_out !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL zero_env: rdy=%b out=%0d required 1 0", out_ready, sample_out);
    end
    attack_step = 16'd100;
    pulse(1'b1, 16'sd0);
    pulse(1'b1, 16'sd0);
    attack_step = 16'd65535;
    pulse(1'b1, 16'sd0);
    checks++;
    if (env_state !== 3'd2 || env_level !== 16'd65535) begin
      errors++;
      $display("[TB] FAIL saturate: state=%0d env=%0d required 2 65535", env_state, env_level);
    end
    sustain_level = 16'd65535;
    decay_step    = 16'd1;
    pulse(1'b1, 16'sh7FFF);
    checks++;
    if (env_state !== 3'd3 || env_level !== 16'd65535) begin
      errors++;
      $display("[TB] FAIL sustain_full: state=%0d env=%0d required 3 65535", env_state, env_level);
    end
    @(negedge clk);
    checks++;
    if (sample_out !== 16'sd32766) begin
      errors++;
      $display("[TB] FAIL full_scale_out: out=%0d required 32766", sample_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    attack_step   = 16'd65535;
    decay_step    = 16'd65535;
    sustain_level = 16'd32768;
    pulse(1'b1, 16'sd0);
    pulse(1'b1, 16'sd0);
    pulse(1'b1, 16'sd0);
    checks++;
    if (env_state !== 3'd3 || env_level !== 16'd32768) begin
      errors++;
      $display("[TB] FAIL b2b_setup: state=%0d env=%0d required 3 32768", env_state, env_level);
    end
    @(negedge clk);
    in_ready  = 1'b1;
    gate      = 1'b1;
    sample_in = 16'sd1000;
    @(negedge clk);
    sample_in = -16'sd1000;
    @(negedge clk);
    in_ready = 1'b0;
    checks++;
    if (out_ready !== 1'b1 || sample_out !== 16'sd500) begin
      errors++;
      $display("[TB] FAIL b2b_first: rdy=%b out=%0d required 1 500", out_ready, sample_out);
    end
    @(negedge clk);
    checks++;
    if (out_ready !== 1'b1 || sample_out !== -16'sd500) begin
      errors++;
      $display("[TB] FAIL b2b_second: rdy=%b out=%0d required 1 -500", out_ready, sample_out);
    end
    @(negedge clk);
    checks++;
    if (out_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_end: rdy=%b required 0", out_ready);
    end
    sustain_level = 16'd20000;
    pulse(1'b1, 16'sd0);
    checks++;
    if (env_state !== 3'd3 || env_level !== 16'd20000) begin
      errors++;
      $display("[TB] FAIL sustain_track: state=%0d env=%0d required 3 20000", env_state, env_level);
    end
  endtask

  // Test sequence.
  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    in_ready      = 1'b0;
    gate          = 1'b0;
    sample_in     = '0;
    attack_step   = '0;
    decay_step    = '0;
    sustain_level = '0;
    release_step  = '0;
    test_reset();
    test_full_cycle();
    test_latency();
    test_early_release_retrigger();
    test_saturation_zero();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
